store_trace_fifo: RTL

- Sits directly downstream of the single-cycle processor top and consumes its data-memory write bus (MemWrite, DataAdr, WriteData).
- Captures every processor store into a small first-word-fall-through (FWFT) FIFO for a valid/ready consumer such as a trace drain or debug port.
- Keeps a saturating store counter and a sticky overflow flag.
- Runs a pass/fail detector on stores to a designated "result" address, replacing ad-hoc bench checks with a hardware verdict.

---
 rtl/store_trace_fifo.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/store_trace_fifo.sv
// Store trace capture: FWFT FIFO of processor stores, saturating store counter,
// sticky overflow and pass/fail detector. Optional address window: STORE_TRACE_FILTER_EN.
module store_trace_fifo #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] DONE_ADR = 32'd100,
    parameter logic [31:0] DONE_VAL = 32'd25,
    parameter int unsigned CNT_W    = 16
`ifdef STORE_TRACE_FILTER_EN
    ,
    parameter logic [31:0] FILT_LO  = 32'h0,
    parameter logic [31:0] FILT_HI  = 32'h0000_00FF
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       MemWrite,
    input  logic [31:0]                DataAdr,
    input  logic [31:0]                WriteData,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [31:0]                OutAdr,
    output logic [31:0]                OutData,
    output logic [$clog2(DEPTH):0]     Level,
    output logic                       Full,
    output logic                       Overflow,
    input  logic                       ClrOverflow,
    output logic [CNT_W-1:0]           StoreCount,
    output logic                       Pass,
    output logic                       Fail
);

    // state | meaning
    // IDLE  | no store to DONE_ADR seen yet
    // PASS  | first store to DONE_ADR carried DONE_VAL (terminal)
    // FAIL  | first store to DONE_ADR carried another value (terminal)

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } det_state_e;

    logic [31:0]      mem_adr  [DEPTH];
    logic [31:0]      mem_data [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [31:0]      out_adr_q, out_adr_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] count_q, count_d;
    det_state_e       state_q;
    logic             pass_q, fail_q;

    logic             in_window;
    logic             full;
    logic             push;
    logic             pop;
    logic             ovf_set;
    logic [PTR_W-1:0] rd_next;

    always_comb begin
`ifdef STORE_TRACE_FILTER_EN
        in_window = (DataAdr >= FILT_LO) && (DataAdr <= FILT_HI);
`else
        in_window = 1'b1;
`endif
        full    = (level_q == LVL_W'(DEPTH));
        pop     = (level_q != '0) && OutReady;
        push    = MemWrite && in_window && (!full || pop);
        ovf_set = MemWrite && in_window && full && !pop;
        rd_next = rd_ptr_q + PTR_W'(1);

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_next              : rd_ptr_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end

        // Head registers are loaded with whatever entry will be oldest next cycle;
        // when the FIFO drains they simply keep their last value.
        out_adr_d  = out_adr_q;
        out_data_d = out_data_q;
        if (pop && level_q > LVL_W'(1)) begin
            out_adr_d  = mem_adr[rd_next];
            out_data_d = mem_data[rd_next];
        end else if (push && (level_q == '0 || (pop && level_q == LVL_W'(1)))) begin
            out_adr_d  = DataAdr;
            out_data_d = WriteData;
        end

        overflow_d = overflow_q;
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (ClrOverflow) begin
            overflow_d = 1'b0;
        end

        count_d = count_q;
        if (MemWrite && count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_adr[wr_ptr_q]  <= DataAdr;
            mem_data[wr_ptr_q] <= WriteData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            out_adr_q  <= '0;
            out_data_q <= '0;
            overflow_q <= 1'b0;
            count_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            out_adr_q  <= out_adr_d;
            out_data_q <= out_data_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
        end
    end

    // Detector sees every store, filtered or dropped alike.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (MemWrite && DataAdr == DONE_ADR) begin
                        if (WriteData == DONE_VAL) begin
                            state_q <= ST_PASS;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q <= ST_FAIL;
                            fail_q  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign OutValid   = (level_q != '0);
    assign OutAdr     = out_adr_q;
    assign OutData    = out_data_q;
    assign Level      = level_q;
    assign Full       = full;
    assign Overflow   = overflow_q;
    assign StoreCount = count_q;
    assign Pass       = pass_q;
    assign Fail       = fail_q;

endmodule
